// File: rtl/cond_pkg.sv
// Condition codes, NZCV bit positions and the E-stage control bundle.
// Shared by the condition checker, the pipeline registers and the bench.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       flagw;
    logic       memtoreg;
    logic       alusrc;
    logic       nowrite;
    logic [1:0] alu_ctl;
    logic [3:0] cond;
  } e_ctrl_t;

  localparam int unsigned E_CTRL_W = $bits(e_ctrl_t);

  // A bubble must not write anything; AL keeps it harmless if it ever reaches the checker.
  localparam e_ctrl_t E_BUBBLE = '{pcs: 1'b0, regw: 1'b0, memw: 1'b0, flagw: 1'b0,
                                   memtoreg: 1'b0, alusrc: 1'b0, nowrite: 1'b0,
                                   alu_ctl: 2'b00, cond: COND_AL};

endpackage

// File: rtl/cond_exec_pipe_if.sv
// Decode-side control bundle in, gated E/M/W controls and flags out.
// master = decoder/hazard side driving it, slave = the condition pipeline.
interface cond_exec_pipe_if;
  logic       PCSD, RegWD, MemWD, FlagWD, MemtoRegD, ALUSrcD, NoWriteD;
  logic [1:0] ALUControlD;
  logic [3:0] CondD;
  logic [3:0] ALUFlagsE;
  logic       StallE, FlushE;
  logic [1:0] ALUControlE;
  logic       ALUSrcE, MemtoRegE, PCSrcE;
  logic       PCSrcM, PCSrcW, RegWriteM, RegWriteW, MemWriteM, MemtoRegM, MemtoRegW;
  logic [3:0] FlagsQ;

  modport master (
    output PCSD, RegWD, MemWD, FlagWD, MemtoRegD, ALUSrcD, NoWriteD, ALUControlD, CondD,
           ALUFlagsE, StallE, FlushE,
    input  ALUControlE, ALUSrcE, MemtoRegE, PCSrcE, PCSrcM, PCSrcW, RegWriteM, RegWriteW,
           MemWriteM, MemtoRegM, MemtoRegW, FlagsQ
  );

  modport slave (
    input  PCSD, RegWD, MemWD, FlagWD, MemtoRegD, ALUSrcD, NoWriteD, ALUControlD, CondD,
           ALUFlagsE, StallE, FlushE,
    output ALUControlE, ALUSrcE, MemtoRegE, PCSrcE, PCSrcM, PCSrcW, RegWriteM, RegWriteW,
           MemWriteM, MemtoRegM, MemtoRegW, FlagsQ
  );
endinterface

// File: rtl/cond_check.sv
// ARM condition evaluation: (cond, NZCV) -> execute. Purely combinational, 0 latency.
// No state, no backpressure; 1111 never executes.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_pipe.sv
// Registers decode controls into E, gates write enables on the condition, owns NZCV, pipes to M/W.
// D->E 1 cycle, E->M 1, M->W 1; StallE holds E only, M/W always advance, FlushE wins over StallE.
module cond_exec_pipe
  import cond_pkg::*;
(
  input  logic             CLK,
  input  logic             RESETn,
  cond_exec_pipe_if.slave  bus
);

  e_ctrl_t    e_d, e_q;
  logic [3:0] flags_d, flags_q;
  logic       pcsrc_m_d, pcsrc_m_q, regwrite_m_d, regwrite_m_q;
  logic       memwrite_m_d, memwrite_m_q, memtoreg_m_d, memtoreg_m_q;
  logic       pcsrc_w_d, pcsrc_w_q, regwrite_w_d, regwrite_w_q, memtoreg_w_d, memtoreg_w_q;
  logic       cond_ex_e, pcsrc_e, regwrite_e, memwrite_e, flagwrite_e;

  cond_check u_cond_check (
    .cond    (e_q.cond),
    .flags   (flags_q),
    .cond_ex (cond_ex_e)
  );

  assign pcsrc_e     = e_q.pcs & cond_ex_e;
  assign regwrite_e  = e_q.regw & cond_ex_e & !e_q.nowrite;
  assign memwrite_e  = e_q.memw & cond_ex_e;
  // CMP/CMN set NoWrite but must still update flags.
  assign flagwrite_e = e_q.flagw & cond_ex_e;

  always_comb begin
    e_d = e_q;
    if (bus.FlushE) begin
      e_d = E_BUBBLE;
    end else if (!bus.StallE) begin
      e_d = '{pcs: bus.PCSD, regw: bus.RegWD, memw: bus.MemWD, flagw: bus.FlagWD,
              memtoreg: bus.MemtoRegD, alusrc: bus.ALUSrcD, nowrite: bus.NoWriteD,
              alu_ctl: bus.ALUControlD, cond: bus.CondD};
    end
  end

  always_comb begin
    flags_d      = flagwrite_e ? bus.ALUFlagsE : flags_q;
    pcsrc_m_d    = pcsrc_e;
    regwrite_m_d = regwrite_e;
    memwrite_m_d = memwrite_e;
    memtoreg_m_d = e_q.memtoreg;
    pcsrc_w_d    = pcsrc_m_q;
    regwrite_w_d = regwrite_m_q;
    memtoreg_w_d = memtoreg_m_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      e_q          <= E_BUBBLE;
      flags_q      <= 4'b0000;
      pcsrc_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      pcsrc_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
    end else begin
      e_q          <= e_d;
      flags_q      <= flags_d;
      pcsrc_m_q    <= pcsrc_m_d;
      regwrite_m_q <= regwrite_m_d;
      memwrite_m_q <= memwrite_m_d;
      memtoreg_m_q <= memtoreg_m_d;
      pcsrc_w_q    <= pcsrc_w_d;
      regwrite_w_q <= regwrite_w_d;
      memtoreg_w_q <= memtoreg_w_d;
    end
  end

  assign bus.ALUControlE = e_q.alu_ctl;
  assign bus.ALUSrcE     = e_q.alusrc;
  assign bus.MemtoRegE   = e_q.memtoreg;
  assign bus.PCSrcE      = pcsrc_e;
  assign bus.PCSrcM      = pcsrc_m_q;
  assign bus.PCSrcW      = pcsrc_w_q;
  assign bus.RegWriteM   = regwrite_m_q;
  assign bus.RegWriteW   = regwrite_w_q;
  assign bus.MemWriteM   = memwrite_m_q;
  assign bus.MemtoRegM   = memtoreg_m_q;
  assign bus.MemtoRegW   = memtoreg_w_q;
  assign bus.FlagsQ      = flags_q;

endmodule

// File: tb/tb_cond_exec_pipe.sv
// Directed bench for cond_exec_pipe: flag-setting/branch sequences, condition sweep,
// flush/stall interaction and asynchronous reset.
module tb_cond_exec_pipe;
  import cond_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cond_exec_pipe_if bus ();

  cond_exec_pipe dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic pcs, input logic regw, input logic memw, input logic flagw,
                       input logic memtoreg, input logic alusrc, input logic nowrite,
                       input logic [1:0] alu, input logic [3:0] cond);
    bus.PCSD        = pcs;
    bus.RegWD       = regw;
    bus.MemWD       = memw;
    bus.FlagWD      = flagw;
    bus.MemtoRegD   = memtoreg;
    bus.ALUSrcD     = alusrc;
    bus.NoWriteD    = nowrite;
    bus.ALUControlD = alu;
    bus.CondD       = cond;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 2'b00, COND_AL);
  endtask

  // Reference table written as base condition on cond[3:1], inverted by cond[0].
  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] && !f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    nop();
    bus.ALUFlagsE = 4'b0000;
    bus.StallE    = 1'b0;
    bus.FlushE    = 1'b0;
    #2;
    chk("rst_pcsrc_e", {3'b0, bus.PCSrcE}, 4'h0);
    chk("rst_flags", bus.FlagsQ, 4'h0);
    tick();
    tick();
    chk("rst_aluctl_e", {2'b0, bus.ALUControlE}, 4'h0);
    chk("rst_regwrite_w", {3'b0, bus.RegWriteW}, 4'h0);
    rst_n = 1'b1;

    // SUBS sets Z, BEQ follows
    set_d(0, 1, 0, 1, 0, 0, 0, 2'b01, COND_AL);
    bus.ALUFlagsE = 4'b0100;
    tick();
    set_d(1, 0, 0, 0, 0, 0, 0, 2'b00, COND_EQ);
    tick();
    bus.ALUFlagsE = 4'b0000;
    chk("subs_flags", bus.FlagsQ, 4'b0100);
    chk("beq_pcsrc_e", {3'b0, bus.PCSrcE}, 4'h1);
    chk("subs_regwrite_m", {3'b0, bus.RegWriteM}, 4'h1);
    nop();
    tick();
    chk("beq_pcsrc_m", {3'b0, bus.PCSrcM}, 4'h1);
    tick();
    chk("beq_pcsrc_w", {3'b0, bus.PCSrcW}, 4'h1);

    // CMP: flags update, no register write
    set_d(0, 1, 0, 1, 0, 0, 1, 2'b01, COND_AL);
    bus.ALUFlagsE = 4'b0110;
    tick();
    nop();
    tick();
    chk("cmp_regwrite_m", {3'b0, bus.RegWriteM}, 4'h0);
    chk("cmp_flags", bus.FlagsQ, 4'b0110);

    // ADDNE-store with Z clear, then with Z set
    set_d(0, 0, 0, 1, 0, 0, 0, 2'b00, COND_AL);
    bus.ALUFlagsE = 4'b0000;
    tick();
    set_d(0, 1, 1, 0, 0, 1, 0, 2'b00, COND_NE);
    tick();
    chk("ne_flags0", bus.FlagsQ, 4'b0000);
    nop();
    tick();
    chk("ne_pass_memwrite_m", {3'b0, bus.MemWriteM}, 4'h1);
    tick();
    chk("ne_pass_regwrite_w", {3'b0, bus.RegWriteW}, 4'h1);
    set_d(0, 0, 0, 1, 0, 0, 0, 2'b00, COND_AL);
    bus.ALUFlagsE = 4'b0100;
    tick();
    set_d(0, 1, 1, 0, 0, 1, 0, 2'b00, COND_NE);
    tick();
    chk("ne_flags1", bus.FlagsQ, 4'b0100);
    nop();
    tick();
    chk("ne_fail_memwrite_m", {3'b0, bus.MemWriteM}, 4'h0);
    tick();
    chk("ne_fail_regwrite_w", {3'b0, bus.RegWriteW}, 4'h0);

    // Every condition against every flag value
    for (int f = 0; f < 16; f++) begin
      set_d(0, 0, 0, 1, 0, 0, 0, 2'b00, COND_AL);
      bus.ALUFlagsE = 4'(f);
      tick();
      for (int c = 0; c < 16; c++) begin
        set_d(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'(c));
        tick();
        if (c == 0) chk($sformatf("sweep_flags_%0d", f), bus.FlagsQ, 4'(f));
        chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, bus.PCSrcE},
            {3'b0, exp_cond(4'(c), 4'(f))});
      end
    end

    // Flush beats stall on an incoming STR that would also write flags
    set_d(0, 0, 1, 1, 0, 1, 0, 2'b10, COND_AL);
    bus.ALUFlagsE = 4'b0011;
    bus.FlushE    = 1'b1;
    bus.StallE    = 1'b1;
    tick();
    chk("flush_aluctl_e", {2'b0, bus.ALUControlE}, 4'h0);
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;
    nop();
    tick();
    chk("flush_memwrite_m", {3'b0, bus.MemWriteM}, 4'h0);
    chk("flush_flags", bus.FlagsQ, 4'b1111);

    // Flag write by the instruction leaving E survives a same-edge flush
    set_d(0, 0, 0, 1, 0, 0, 0, 2'b01, COND_AL);
    bus.ALUFlagsE = 4'b1000;
    tick();
    nop();
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    chk("flush_leave_flags", bus.FlagsQ, 4'b1000);

    // Stall for three cycles with a store waiting in D
    set_d(0, 1, 0, 0, 0, 1, 0, 2'b01, COND_AL);
    tick();
    set_d(0, 0, 1, 0, 0, 1, 0, 2'b10, COND_AL);
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_aluctl_%0d", i), {2'b0, bus.ALUControlE}, 4'h1);
      chk($sformatf("stall_memwrite_%0d", i), {3'b0, bus.MemWriteM}, 4'h0);
    end
    bus.StallE = 1'b0;
    tick();
    chk("release_aluctl", {2'b0, bus.ALUControlE}, 4'h2);
    nop();
    tick();
    chk("release_memwrite_pulse", {3'b0, bus.MemWriteM}, 4'h1);
    tick();
    chk("release_memwrite_end", {3'b0, bus.MemWriteM}, 4'h0);

    // Asynchronous reset with live instructions in flight
    set_d(1, 1, 1, 0, 1, 1, 0, 2'b11, COND_AL);
    tick();
    tick();
    chk("pre_rst_memtoreg_e", {3'b0, bus.MemtoRegE}, 4'h1);
    chk("pre_rst_memwrite_m", {3'b0, bus.MemWriteM}, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pcsrc_e", {3'b0, bus.PCSrcE}, 4'h0);
    chk("arst_aluctl_e", {2'b0, bus.ALUControlE}, 4'h0);
    chk("arst_alusrc_e", {3'b0, bus.ALUSrcE}, 4'h0);
    chk("arst_memtoreg_e", {3'b0, bus.MemtoRegE}, 4'h0);
    chk("arst_m", {1'b0, bus.PCSrcM, bus.RegWriteM, bus.MemWriteM}, 4'h0);
    chk("arst_memtoreg_m", {3'b0, bus.MemtoRegM}, 4'h0);
    chk("arst_w", {1'b0, bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW}, 4'h0);
    chk("arst_flags", bus.FlagsQ, 4'h0);
    tick();
    rst_n = 1'b1;
    nop();
    tick();
    chk("post_rst_regwrite_m", {3'b0, bus.RegWriteM}, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_exec_pipe.md
# cond_exec_pipe

Execute-side consumer of the decode-stage control bundle (PCSD, RegWD, MemWD, FlagWD, ALUControlD, MemtoRegD, ALUSrcD, NoWriteD).
- Registers the bundle and the instruction condition field into the Execute stage.
- Evaluates the ARM condition against the architectural NZCV flags register it owns, and gates all write enables.
- Carries the surviving enables through Memory and Writeback.
- Sits between the Decoder and the datapath's E/M/W pipeline registers, replacing the single-cycle CondLogic.

## Interface
Parameters: none; all widths fixed by the ISA.

Ports:
- CLK  in  1  rising-edge clock.
- RESETn  in  1  asynchronous reset, active-low.
- PCSD, RegWD, MemWD, FlagWD, MemtoRegD, ALUSrcD, NoWriteD  in  1 each  decoded controls.
- ALUControlD  in  2  decoded ALU op.
- CondD  in  4  Instr[31:28] of the D-stage instruction.
- ALUFlagsE  in  4  {N,Z,C,V} from the ALU for the E-stage instruction.
- StallE  in  1  hold the E register.
- FlushE  in  1  load a bubble into E.
- ALUControlE  out  2  registered ALU op.
- ALUSrcE  out  1  registered ALU source select.
- MemtoRegE  out  1  registered, ungated; used for load-use detection.
- PCSrcE  out  1  combinational; PCSE & CondExE.
- PCSrcM, PCSrcW  out  1  pipelined PCSrc.
- RegWriteM, RegWriteW  out  1  gated register write.
- MemWriteM  out  1  gated memory write.
- MemtoRegM, MemtoRegW  out  1  pipelined.
- FlagsQ  out  4  architectural NZCV flags.

## Operation
E register captures all D inputs plus CondD at each edge.
- FlushE: E contents become a bubble (PCS, RegW, MemW, FlagW, MemtoReg = 0; CondE = AL).
- StallE: E holds.
- FlushE has priority over StallE.

Condition evaluation, CondExE from CondE and FlagsQ:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V
- GT !Z&(N==V); LE Z|(N!=V); AL 1
- 1111 = never execute (0).

Gated enables:
- PCSrcE = PCSE & CondExE.
- RegWriteE = RegWE & CondExE & !NoWriteE.
- MemWriteE = MemWE & CondExE.
- FlagWriteE = FlagWE & CondExE. NoWrite does not block flag update (CMP/CMN).

Flags: FlagsQ <= ALUFlagsE on an edge with FlagWriteE=1; otherwise held.

Downstream registers:
- E/M register carries PCSrc, RegWrite, MemWrite, MemtoReg.
- M/W register carries PCSrc, RegWrite, MemtoReg.
- Neither has stall or flush; both advance every cycle.

Reset, asynchronous:
- All E/M/W control bits are 0; E holds a bubble.
- ALUControlE = 00, ALUSrcE = 0, FlagsQ = 0000.
- All outputs are therefore 0 during and immediately after reset. Reset mid-pipeline discards in-flight instructions.

## Timing
- D→E: 1 cycle. PCSrcE is valid in the same cycle the instruction is in E.
- E→M: 1 cycle (MemWriteM). M→W: 1 cycle (RegWriteW, PCSrcW).
- Flags written at the end of E of instruction i are seen by instruction i+1 in E the next cycle. No flag forwarding path is needed.
- A stalled E instruction with FlagWE=1 writes flags on every stalled edge with the same ALUFlagsE value. The hazard unit guarantees ALUFlagsE is stable while StallE=1.
- A flushed instruction never writes flags, regs, memory or PC.
- FlushE and a flag write by the instruction leaving E on the same edge: the flag write takes effect.

## Structure
- Package cond_pkg holds:
  - 4-bit condition-code constants COND_EQ..COND_AL, COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - The E-stage control struct/bundle width and the bubble value.
- Sub-module cond_check: purely combinational, (Cond, Flags) → CondEx. Reused by the verification model.
- The remainder is one module containing the E, M and W registers and the flags register.

## Test plan
- Reset: RESETn=0 mid-stream → all outputs 0 and FlagsQ=0000 asynchronously, before the next CLK.
- SUBS then BEQ: SUBS with FlagWD=1, ALUFlagsE=0100 → FlagsQ=0100 next cycle; following CondD=0000, PCSD=1 → PCSrcE=1, PCSrcW=1 two cycles later.
- CMP (RegWD=1, NoWriteD=1, FlagWD=1) → RegWriteM=0, FlagsQ updated.
- Condition fail: FlagsQ=0000, ADDNE-store (CondD=0001, MemWD=1) → MemWriteM=1. Then FlagsQ=0100, same instruction → MemWriteM=0, RegWriteW=0.
- All 16 CondD values × all 16 FlagsQ values: PCSrcE matches the reference table; CondD=1111 always gives 0.
- FlushE=1 with StallE=1 on an STR with FlagWD=1 → E becomes a bubble, MemWriteM=0, FlagsQ unchanged. StallE alone for 3 cycles → ALUControlE held, one MemWriteM pulse after release.
